wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Write-back stage of the in-order RV64 core: the last pipeline register before retirement.
- Accepts one completed instruction per cycle from the memory stage over a valid/ready handshake.
- Forms the final register write value, including load lane selection and extension.
- Drives the integer regfile write port and the commit-side signals consumed by the difftest commit unit. It also flags instructions whose results difftest must skip, counts retired instructions and halts the pipeline on the trap instruction.

Parameters:
- XLEN, 64, datapath width (only 64 is supported).
- MMIO_LIMIT, 64'h0000_0000_8000_0000, load/store addresses strictly below this are MMIO and marked skip.
- TRAP_OPCODE, 7'h6b, opcode of the simulation trap instruction.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  memory stage has an instruction.
- o_ready  out  1  stage can accept this cycle.
- i_pc  in  64  instruction PC.
- i_inst  in  32  instruction word.
- i_rd  in  5  destination register.
- i_rd_wen  in  1  instruction writes rd.
- i_alu_result  in  64  non-load result (ALU/CSR read/link address).
- i_is_load  in  1  instruction is a load.
- i_is_store  in  1  instruction is a store.
- i_load_funct3  in  3  load size/sign.
- i_mem_addr  in  64  effective load/store address.
- i_mem_rdata  in  64  aligned 64-bit doubleword read from memory.
- i_is_csr  in  1  instruction reads a CSR.
- i_csr_addr  in  12  CSR address.
- o_rf_wen  out  1  regfile write enable.
- o_rf_waddr  out  5  regfile write address.
- o_rf_wdata  out  64  regfile write data.
- o_cmt_valid  out  1  one instruction retires this cycle.
- o_cmt_pc  out  64  retiring PC.
- o_cmt_inst  out  32  retiring instruction.
- o_cmt_rd  out  5  retiring rd.
- o_cmt_rd_wen  out  1  retiring write enable.
- o_cmt_rd_wdata  out  64  retiring write data.
- o_cmt_skip  out  1  difftest must skip this instruction.
- o_instret  out  64  retired instruction count.
- o_halted  out  1  trap has retired; pipeline frozen.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0 except o_ready, which is 1.
  - Entry register invalid, o_instret=0, halted=0.
- Accept condition: i_valid && o_ready.
  - On accept, decoded results are captured into the entry register at the rising edge.
  - o_cmt_valid=1 the following cycle. Latency is exactly 1 cycle.
  - With no accept, o_cmt_valid=0 next cycle. Entries never linger for more than one cycle.
- All o_cmt_* and o_rf_* outputs are registered. o_rf_* equals the o_cmt_rd* signals while o_cmt_valid=1, and o_rf_wen=0 otherwise.
- o_ready = ~halted. There is no other backpressure source, so back-to-back accepts sustain 1 IPC.
- x0 rule: if i_rd==0, captured rd_wen=0 and wdata=0, regardless of i_rd_wen.
- Write data selection:
  - i_is_load: extract a lane of i_mem_rdata by i_mem_addr:
    - byte at addr[2:0]*8
    - half at addr[2:1]*16
    - word at addr[2]*32
    - Unused low address bits are ignored.
  - Extension by i_load_funct3:
    - 000 LB sign-extend
    - 001 LH sign-extend
    - 010 LW sign-extend
    - 011 LD full doubleword
    - 100 LBU zero-extend
    - 101 LHU zero-extend
    - 110 LWU zero-extend
    - 111 result 0
  - Otherwise: i_alu_result.
- Skip flag, set when:
  - (i_is_load || i_is_store) && i_mem_addr < MMIO_LIMIT (unsigned 64-bit compare), OR
  - i_is_csr && i_csr_addr in {12'hB00 mcycle, 12'hC00 cycle}.
- Counter: o_instret increments by 1 on every cycle with o_cmt_valid=1 (including skipped instructions). It wraps modulo 2^64.
- Trap / halt:
  - An accepted instruction with inst[6:0]==TRAP_OPCODE retires normally, with o_cmt_valid=1 for its cycle.
  - On that same edge halted becomes 1, so o_halted=1 and o_ready=0 from the retire cycle onward.
  - No further accepts or commits until reset. i_valid is ignored while halted.
- Reset mid-operation: a pending entry is discarded, and o_cmt_valid drops to 0 immediately (asynchronously).

Test Plan:
- Reset then single ADDI (pc=0x8000_0000, rd=5, alu=0x1234) -> next cycle o_cmt_valid=1, o_rf_wen=1, waddr=5, wdata=0x1234, skip=0, o_instret=1 one cycle later.
- LB with addr=0x8000_0003, rdata=0x0000_0000_8000_0000 -> wdata=0xFFFF_FFFF_FFFF_FF80. Same inputs with LBU -> 0x80. LWU at addr=…4 with rdata=0xDEAD_BEEF_0000_0000 -> 0xDEAD_BEEF.
- Write to x0 (rd=0, rd_wen=1, alu=0x55) -> o_cmt_valid=1, o_rf_wen=0, o_cmt_rd_wdata=0.
- Store to 0x1000_0000 -> o_cmt_skip=1. CSR read of 0xB00 -> skip=1. CSR read of 0x300 -> skip=0.
- 10 back-to-back valid instructions -> 10 consecutive o_cmt_valid pulses, o_instret=10, o_ready stays 1.
- Trap (inst=0x0000006b) followed by i_valid held high -> one commit of trap, o_halted=1 and o_ready=0 from that cycle, no further commits. Async rst_n pulse -> o_halted=0, o_ready=1, o_instret=0.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: final pipeline register before retirement.
// Forms regfile write data, flags difftest skips, counts retirements and halts on trap.
module wb_commit_stage #(
    parameter int unsigned XLEN        = 64,
    parameter logic [63:0] MMIO_LIMIT  = 64'h0000_0000_8000_0000,
    parameter logic [6:0]  TRAP_OPCODE = 7'h6b
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_wen,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic [2:0]      i_load_funct3,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_is_csr,
    input  logic [11:0]     i_csr_addr,
    output logic            o_rf_wen,
    output logic [4:0]      o_rf_waddr,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic            o_cmt_valid,
    output logic [XLEN-1:0] o_cmt_pc,
    output logic [31:0]     o_cmt_inst,
    output logic [4:0]      o_cmt_rd,
    output logic            o_cmt_rd_wen,
    output logic [XLEN-1:0] o_cmt_rd_wdata,
    output logic            o_cmt_skip,
    output logic [63:0]     o_instret,
    output logic            o_halted
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [4:0]      rd_q;
    logic            rd_wen_q;
    logic [XLEN-1:0] wdata_q;
    logic            skip_q;
    logic [63:0]     instret_q;
    logic            halted_q;

    logic            accept;
    logic            is_trap;
    logic            rd_wen_d;
    logic            skip_d;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_word;
    logic [XLEN-1:0] wdata_d;

    assign accept  = i_valid && !halted_q;
    assign is_trap = (i_inst[6:0] == TRAP_OPCODE);

    // Lane select from the aligned doubleword; low address bits below the access size are ignored.
    assign ld_byte = i_mem_rdata[{i_mem_addr[2:0], 3'b000} +: 8];
    assign ld_half = i_mem_rdata[{i_mem_addr[2:1], 4'b0000} +: 16];
    assign ld_word = i_mem_rdata[{i_mem_addr[2], 5'b00000} +: 32];

    always_comb begin
        wdata_d = i_alu_result;
        if (i_is_load) begin
            case (i_load_funct3)
                3'b000:  wdata_d = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                3'b001:  wdata_d = {{(XLEN-16){ld_half[15]}}, ld_half};
                3'b010:  wdata_d = {{(XLEN-32){ld_word[31]}}, ld_word};
                3'b011:  wdata_d = i_mem_rdata;
                3'b100:  wdata_d = {{(XLEN-8){1'b0}}, ld_byte};
                3'b101:  wdata_d = {{(XLEN-16){1'b0}}, ld_half};
                3'b110:  wdata_d = {{(XLEN-32){1'b0}}, ld_word};
                default: wdata_d = '0;
            endcase
        end
        if (i_rd == 5'd0) begin
            wdata_d = '0;
        end
    end

    assign rd_wen_d = i_rd_wen && (i_rd != 5'd0);
    assign skip_d   = ((i_is_load || i_is_store) && (i_mem_addr < MMIO_LIMIT))
                   || (i_is_csr && ((i_csr_addr == 12'hB00) || (i_csr_addr == 12'hC00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            wdata_q   <= '0;
            skip_q    <= 1'b0;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            valid_q  <= accept;
            rd_wen_q <= accept && rd_wen_d;
            skip_q   <= accept && skip_d;
            if (accept) begin
                pc_q    <= i_pc;
                inst_q  <= i_inst;
                rd_q    <= i_rd;
                wdata_q <= wdata_d;
                // Trap retires this edge and freezes the stage from its commit cycle on.
                if (is_trap) begin
                    halted_q <= 1'b1;
                end
            end
            if (valid_q) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign o_ready        = !halted_q;
    assign o_cmt_valid    = valid_q;
    assign o_cmt_pc       = pc_q;
    assign o_cmt_inst     = inst_q;
    assign o_cmt_rd       = rd_q;
    assign o_cmt_rd_wen   = rd_wen_q;
    assign o_cmt_rd_wdata = wdata_q;
    assign o_cmt_skip     = skip_q;
    assign o_rf_wen       = rd_wen_q;
    assign o_rf_waddr     = rd_q;
    assign o_rf_wdata     = wdata_q;
    assign o_instret      = instret_q;
    assign o_halted       = halted_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_pc = '0;
    logic [31:0] i_inst = '0;
    logic [4:0]  i_rd = '0;
    logic        i_rd_wen = 1'b0;
    logic [63:0] i_alu_result = '0;
    logic        i_is_load = 1'b0;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_load_funct3 = '0;
    logic [63:0] i_mem_addr = '0;
    logic [63:0] i_mem_rdata = '0;
    logic        i_is_csr = 1'b0;
    logic [11:0] i_csr_addr = '0;
    logic        o_rf_wen;
    logic [4:0]  o_rf_waddr;
    logic [63:0] o_rf_wdata;
    logic        o_cmt_valid;
    logic [63:0] o_cmt_pc;
    logic [31:0] o_cmt_inst;
    logic [4:0]  o_cmt_rd;
    logic        o_cmt_rd_wen;
    logic [63:0] o_cmt_rd_wdata;
    logic        o_cmt_skip;
    logic [63:0] o_instret;
    logic        o_halted;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_cnt = '0;
    logic        m_halted = 1'b0;

    wb_commit_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_pc           (i_pc),
        .i_inst         (i_inst),
        .i_rd           (i_rd),
        .i_rd_wen       (i_rd_wen),
        .i_alu_result   (i_alu_result),
        .i_is_load      (i_is_load),
        .i_is_store     (i_is_store),
        .i_load_funct3  (i_load_funct3),
        .i_mem_addr     (i_mem_addr),
        .i_mem_rdata    (i_mem_rdata),
        .i_is_csr       (i_is_csr),
        .i_csr_addr     (i_csr_addr),
        .o_rf_wen       (o_rf_wen),
        .o_rf_waddr     (o_rf_waddr),
        .o_rf_wdata     (o_rf_wdata),
        .o_cmt_valid    (o_cmt_valid),
        .o_cmt_pc       (o_cmt_pc),
        .o_cmt_inst     (o_cmt_inst),
        .o_cmt_rd       (o_cmt_rd),
        .o_cmt_rd_wen   (o_cmt_rd_wen),
        .o_cmt_rd_wdata (o_cmt_rd_wdata),
        .o_cmt_skip     (o_cmt_skip),
        .o_instret      (o_instret),
        .o_halted       (o_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference write data: pick an access-size-aligned lane by byte offset, then extend.
    function automatic logic [63:0] model_wdata(input logic ld, input logic [2:0] f3,
                                                input logic [63:0] addr, input logic [63:0] data,
                                                input logic [63:0] alu, input logic [4:0] rd);
        int          nbytes;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        if (rd == 5'd0) return 64'd0;
        if (!ld) return alu;
        if (f3 == 3'b111) return 64'd0;
        nbytes = 1 << f3[1:0];
        if (nbytes == 8) return data;
        off  = (int'(addr % 64'd8) / nbytes) * nbytes;
        v    = data >> (off * 8);
        mask = (64'd1 << (nbytes * 8)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[nbytes*8-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic model_skip(input logic ld, input logic st, input logic [63:0] addr,
                                        input logic csr, input logic [11:0] ca);
        return ((ld || st) && (addr < 64'h8000_0000)) || (csr && (ca == 12'hB00 || ca == 12'hC00));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [63:0] p, input logic [31:0] in, input logic [4:0] r,
                            input logic we, input logic [63:0] a, input logic ld, input logic st,
                            input logic [2:0] f, input logic [63:0] ad, input logic [63:0] dat,
                            input logic c, input logic [11:0] ca);
        i_valid = 1'b1; i_pc = p; i_inst = in; i_rd = r; i_rd_wen = we; i_alu_result = a;
        i_is_load = ld; i_is_store = st; i_load_funct3 = f; i_mem_addr = ad; i_mem_rdata = dat;
        i_is_csr = c; i_csr_addr = ca;
    endtask

    // One clock with the current inputs, checked against the model.
    task automatic cycle(input string tag);
        logic        acc;
        logic [63:0] ew;
        logic        es;
        logic        ewe;
        acc = i_valid && !m_halted;
        ew  = model_wdata(i_is_load, i_load_funct3, i_mem_addr, i_mem_rdata, i_alu_result, i_rd);
        es  = model_skip(i_is_load, i_is_store, i_mem_addr, i_is_csr, i_csr_addr);
        ewe = i_rd_wen && (i_rd != 5'd0);
        if (acc && i_inst[6:0] == 7'h6b) m_halted = 1'b1;
        step();
        chk({tag, ".valid"}, o_cmt_valid, acc);
        chk({tag, ".instret"}, o_instret, m_cnt);
        chk({tag, ".halted"}, o_halted, m_halted);
        chk({tag, ".ready"}, o_ready, !m_halted);
        if (acc) begin
            chk({tag, ".pc"}, o_cmt_pc, i_pc);
            chk({tag, ".inst"}, o_cmt_inst, i_inst);
            chk({tag, ".rd"}, o_cmt_rd, i_rd);
            chk({tag, ".rd_wen"}, o_cmt_rd_wen, ewe);
            chk({tag, ".wdata"}, o_cmt_rd_wdata, ew);
            chk({tag, ".skip"}, o_cmt_skip, es);
            chk({tag, ".rf_wen"}, o_rf_wen, ewe);
            chk({tag, ".rf_waddr"}, o_rf_waddr, i_rd);
            chk({tag, ".rf_wdata"}, o_rf_wdata, ew);
            m_cnt++;
        end else begin
            chk({tag, ".rf_wen_idle"}, o_rf_wen, 1'b0);
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt    = '0;
        m_halted = 1'b0;
        chk({tag, ".valid"}, o_cmt_valid, 1'b0);
        chk({tag, ".rf_wen"}, o_rf_wen, 1'b0);
        chk({tag, ".instret"}, o_instret, 64'd0);
        chk({tag, ".halted"}, o_halted, 1'b0);
        chk({tag, ".ready"}, o_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] addr;
        logic [31:0] inst;

        // Reset state
        #3;
        chk("rst.valid", o_cmt_valid, 1'b0);
        chk("rst.ready", o_ready, 1'b1);
        chk("rst.rf_wen", o_rf_wen, 1'b0);
        chk("rst.wdata", o_cmt_rd_wdata, 64'd0);
        chk("rst.pc", o_cmt_pc, 64'd0);
        chk("rst.instret", o_instret, 64'd0);
        chk("rst.halted", o_halted, 1'b0);
        chk("rst.skip", o_cmt_skip, 1'b0);
        step();
        rst_n = 1'b1;

        // ADDI, then instret visible one cycle after commit
        set_inst(64'h8000_0000, 32'h2340_0293, 5'd5, 1'b1, 64'h1234, 0, 0, 3'd0, 0, 0, 0, 0);
        cycle("addi");
        chk("addi.lit_wdata", o_rf_wdata, 64'h1234);
        i_valid = 1'b0;
        cycle("idle1");
        chk("addi.lit_instret", o_instret, 64'd1);

        // Loads
        set_inst(64'h8000_0004, 32'h0000_0283, 5'd6, 1'b1, 0, 1, 0, 3'b000,
                 64'h8000_0003, 64'h0000_0000_8000_0000, 0, 0);
        cycle("lb");
        chk("lb.lit", o_rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        i_load_funct3 = 3'b100;
        cycle("lbu");
        chk("lbu.lit", o_rf_wdata, 64'h80);
        set_inst(64'h8000_000c, 32'h0000_6283, 5'd7, 1'b1, 0, 1, 0, 3'b110,
                 64'h8000_0004, 64'hDEAD_BEEF_0000_0000, 0, 0);
        cycle("lwu");
        chk("lwu.lit", o_rf_wdata, 64'hDEAD_BEEF);

        // x0 write suppressed
        set_inst(64'h8000_0010, 32'h0550_0013, 5'd0, 1'b1, 64'h55, 0, 0, 3'd0, 0, 0, 0, 0);
        cycle("x0");
        chk("x0.lit_wdata", o_cmt_rd_wdata, 64'd0);

        // Skip flag cases
        set_inst(64'h8000_0014, 32'h0000_3023, 5'd0, 1'b0, 0, 0, 1, 3'd0,
                 64'h1000_0000, 0, 0, 0);
        cycle("st_mmio");
        chk("st_mmio.lit", o_cmt_skip, 1'b1);
        set_inst(64'h8000_0018, 32'hB000_2373, 5'd6, 1'b1, 64'h77, 0, 0, 3'd0, 0, 0, 1, 12'hB00);
        cycle("csr_b00");
        chk("csr_b00.lit", o_cmt_skip, 1'b1);
        i_csr_addr = 12'h300;
        cycle("csr_300");
        chk("csr_300.lit", o_cmt_skip, 1'b0);

        // Async reset with a pending entry
        set_inst(64'h8000_001c, 32'h0010_0093, 5'd1, 1'b1, 64'h1, 0, 0, 3'd0, 0, 0, 0, 0);
        cycle("pre_rst");
        async_reset("mid_rst");

        // 10 back-to-back accepts
        for (int k = 0; k < 10; k++) begin
            set_inst(64'h8000_0100 + 64'(k * 4), 32'h0000_0013, 5'(k + 1), 1'b1,
                     64'($urandom), 0, 0, 3'd0, 0, 0, 0, 0);
            cycle("b2b");
        end
        i_valid = 1'b0;
        cycle("b2b_idle");
        chk("b2b.lit_instret", o_instret, 64'd10);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       addr = {32'h0, 1'b0, 31'($urandom)};
                1:       addr = 64'h8000_0000 - 64'($urandom_range(0, 1));
                default: addr = {$urandom, $urandom};
            endcase
            inst = $urandom;
            if (inst[6:0] == 7'h6b) inst[0] = ~inst[0];
            set_inst({$urandom, $urandom}, inst, 5'($urandom), 1'($urandom), {$urandom, $urandom},
                     1'($urandom), 1'($urandom), 3'($urandom), addr, {$urandom, $urandom},
                     1'($urandom), ($urandom_range(0, 1) != 0) ? 12'hC00 : 12'($urandom));
            i_valid = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        // Trap, then valid held high
        set_inst(64'h8000_0200, 32'h0000_006b, 5'd0, 1'b0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        cycle("trap");
        chk("trap.lit_halted", o_halted, 1'b1);
        chk("trap.lit_ready", o_ready, 1'b0);
        set_inst(64'h8000_0204, 32'h0010_0093, 5'd1, 1'b1, 64'h9, 0, 0, 3'd0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle("halted");
        end
        async_reset("final_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
